// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: synchronises and de-glitches SCL/SDA, assembles
// start/8 data/odd parity/stop frames and reports each scan code or framing fault.
module ps2_frame_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SDA,
  input  logic       SCL,
  output logic [7:0] RX_data,
  output logic       VALID,
  output logic       ERROR,
  output logic       BUSY
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // Line index 0 is SCL, 1 is SDA.
  logic [1:0]     sync1_q, sync2_q, filt_q;
  logic [FCW-1:0] filt_cnt_q [2];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      for (int i = 0; i < 2; i++) filt_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {SDA, SCL};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (filt_cnt_q[i] == FCW'(FILTER_LEN - 1)) begin
            filt_q[i]     <= sync2_q[i];
            filt_cnt_q[i] <= '0;
          end else begin
            filt_cnt_q[i] <= filt_cnt_q[i] + 1'b1;
          end
        end else begin
          filt_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic          scl_prev_q;
  logic          fall;
  logic          sda_f;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  assign fall  = scl_prev_q & ~filt_q[0];
  assign sda_f = filt_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    timer_d   = timer_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    if (state_q == StIdle) begin
      if (fall) begin
        if (!sda_f) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
          timer_d   = TW'(TIMEOUT_CYCLES);
        end else begin
          error_d = 1'b1;
        end
      end
    end else if (fall) begin
      timer_d = TW'(TIMEOUT_CYCLES);
      unique case (state_q)
        StData: begin
          shift_d = {sda_f, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StParity: begin
          parity_d = sda_f;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (sda_f && (^{shift_q, parity_q})) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (timer_q <= TW'(1)) begin
      // Stalled frame: drop it and wait for a fresh start bit.
      state_d = StIdle;
      timer_d = '0;
      error_d = 1'b1;
    end else begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      scl_prev_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      timer_q    <= '0;
      rx_data_q  <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      scl_prev_q <= filt_q[0];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      timer_q    <= timer_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign RX_data = rx_data_q;
  assign VALID   = valid_q;
  assign ERROR   = error_q;
  assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: frame tasks push expected VALID/ERROR events,
// a negedge monitor pops and checks them, including exact cycle of arrival.
module tb_ps2_frame_rx;

  localparam int unsigned FilterLen = 4;
  localparam int unsigned Timeout   = 200;
  localparam int unsigned Half      = 20;            // half PS/2 bit period in CLOCK cycles
  localparam int unsigned Lat       = FilterLen + 3; // raw SCL fall -> VALID/ERROR

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sda = 1'b1;
  logic       scl = 1'b1;
  logic [7:0] rx_data;
  logic       valid, error, busy;

  always #5 clk = ~clk;

  ps2_frame_rx #(
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .CLOCK  (clk),
    .RESET  (rst),
    .SDA    (sda),
    .SCL    (scl),
    .RX_data(rx_data),
    .VALID  (valid),
    .ERROR  (error),
    .BUSY   (busy)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  rx;
    int unsigned at;
  } ev_t;

  ev_t         sb[$];
  int          assertions = 0;
  int          failures   = 0;
  int unsigned cyc        = 0;
  logic [7:0]  model_rx   = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 || error === 1'b1) begin
        assertions++;
        if (valid === 1'b1 && error === 1'b1) begin
          failures++;
          $display("FAIL pulse_overlap: VALID=%b ERROR=%b at cycle %0d, required not both", valid,
                   error, cyc);
        end
        assertions++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: VALID=%b ERROR=%b at cycle %0d, required no pulse",
                   valid, error, cyc);
        end else begin
          e = sb.pop_front();
          assertions++;
          if (error !== e.is_err) begin
            failures++;
            $display("FAIL event_kind: ERROR=%b VALID=%b, required ERROR=%b", error, valid,
                     e.is_err);
          end
          assertions++;
          if (rx_data !== e.rx) begin
            failures++;
            $display("FAIL event_rx_data: got %h, required %h", rx_data, e.rx);
          end
          assertions++;
          if (cyc !== e.at) begin
            failures++;
            $display("FAIL event_cycle: got %0d, required %0d", cyc, e.at);
          end
          assertions++;
          if (busy !== 1'b0) begin
            failures++;
            $display("FAIL event_busy: BUSY=%b with pulse, required 0", busy);
          end
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit; optionally queue the event its falling edge should cause.
  task automatic send_bit(input logic b, input bit push, input bit is_err, input logic [7:0] rx,
                          input int unsigned extra, input bit chk_busy);
    sda = b;
    tick(Half);
    if (chk_busy) begin
      assertions++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_frame: BUSY=%b, required 1", busy);
      end
    end
    scl = 1'b0;
    if (push) sb.push_back('{is_err, rx, cyc + Lat + extra});
    tick(Half);
    scl = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    bit good;
    good = (stop == 1'b1) && ((^{data, par}) == 1'b1);
    send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i], 1'b0, 1'b0, 8'h00, 0, 1'b1);
    send_bit(par, 1'b0, 1'b0, 8'h00, 0, 1'b1);
    if (good) model_rx = data;
    send_bit(stop, 1'b1, !good, model_rx, 0, 1'b1);
    sda = 1'b1;
  endtask

  task automatic drain(input string name);
    tick(Lat + 10);
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_events: %0d pending, required 0", name, sb.size());
    end
    sb.delete();
    assertions++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_idle: BUSY=%b, required 0", name, busy);
    end
    assertions++;
    if (rx_data !== model_rx) begin
      failures++;
      $display("FAIL %s_rx_data: got %h, required %h", name, rx_data, model_rx);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    assertions++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL %s_rx_data: got %h, required 00", name, rx_data);
    end
    assertions++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid: got %b, required 0", name, valid);
    end
    assertions++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL %s_error: got %b, required 0", name, error);
    end
    assertions++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_glitch();
    scl = 1'b0;
    tick(FilterLen - 1);
    scl = 1'b1;
    tick(20);
    drain("glitch");
  endtask

  task automatic test_idle_framing();
    send_bit(1'b1, 1'b1, 1'b1, model_rx, 0, 1'b0);
    drain("idle_framing");
  endtask

  task automatic test_bad_parity();
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("bad_parity");
  endtask

  task automatic test_single_frame();
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("single_frame");
  endtask

  task automatic test_back_to_back();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("back_to_back");
  endtask

  task automatic test_bad_stop();
    send_frame(8'h32, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1);
    drain("bad_stop");
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    d = 8'h15;
    send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i], (i == 4), 1'b1, model_rx, Timeout, 1'b1);
    sda = 1'b1;
    tick(Timeout);
    drain("timeout");
    send_frame(8'h45, 1'b0, 1'b1);
    drain("after_timeout");
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1);
    sda = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    model_rx = 8'h00;
    check_reset_outputs("reset_mid_frame");
    rst = 1'b0;
    tick(2 * Timeout);
    drain("reset_mid_frame_quiet");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_idle_framing();
    test_bad_parity();
    test_single_frame();
    test_back_to_back();
    test_bad_stop();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
